// File: rtl/gauss_feeder.sv
// gauss_feeder: walks an IMG_W x IMG_H pixel RAM and runs one Gaussian filter bus transaction per interior pixel.
// Optional poll timeout is enabled by defining GAUSS_FEEDER_TIMEOUT_EN.
module gauss_feeder #(
  parameter int unsigned IMG_W    = 8,
  parameter int unsigned IMG_H    = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned POLL_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic              sel_o,
  output logic              we_o,
  output logic [31:0]       wdata_o,
  input  logic [31:0]       rdata_i,
  output logic              res_we_o,
  output logic [ADDR_W-1:0] res_addr_o,
  output logic [7:0]        res_data_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CTRL  = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_STORE = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] x;
  logic [ADDR_W-1:0] y;
  logic [3:0]        k;
  logic [7:0]        res_q;
  logic              x_wrap;
  logic              last_win;
  logic [3:0]        next_tap;
  logic              unused_bits;

  // Row-major 3x3 window around (xx, yy); tap t sits at row t/3, column t%3.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] xx,
                                                 input logic [ADDR_W-1:0] yy,
                                                 input logic [3:0]        t);
    logic [31:0] row;
    logic [31:0] col;
    row = 32'(yy) - 32'd1 + 32'(t / 4'd3);
    col = 32'(xx) - 32'd1 + 32'(t % 4'd3);
    return ADDR_W'(row * IMG_W + col);
  endfunction

  assign x_wrap      = (x == ADDR_W'(IMG_W - 2));
  assign last_win    = x_wrap && (y == ADDR_W'(IMG_H - 2));
  assign next_tap    = (k == 4'd8) ? 4'd8 : k + 4'd1;
  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_STORE) && last_win;
  assign unused_bits = ^rdata_i[31:8];

`ifdef GAUSS_FEEDER_TIMEOUT_EN
  logic        err_q;
  logic [31:0] poll_cnt;
  assign err_o = err_q;
`else
  logic unused_cfg;
  assign err_o      = 1'b0;
  assign unused_cfg = (POLL_MAX != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      x     <= ADDR_W'(1);
      y     <= ADDR_W'(1);
      k     <= '0;
      res_q <= '0;
`ifdef GAUSS_FEEDER_TIMEOUT_EN
      err_q    <= 1'b0;
      poll_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            x     <= ADDR_W'(1);
            y     <= ADDR_W'(1);
            k     <= '0;
            state <= S_CTRL;
`ifdef GAUSS_FEEDER_TIMEOUT_EN
            err_q <= 1'b0;
`endif
          end
        end
        S_CTRL: begin
          k     <= '0;
          state <= S_SEND;
        end
        S_SEND: begin
          if (k == 4'd8) begin
            k     <= '0;
            state <= S_WAIT;
`ifdef GAUSS_FEEDER_TIMEOUT_EN
            poll_cnt <= '0;
`endif
          end else begin
            k <= k + 4'd1;
          end
        end
        S_WAIT: begin
          // A done seen on the final poll cycle still wins over the timeout.
          if (rdata_i[1]) begin
            state <= S_READ;
          end
`ifdef GAUSS_FEEDER_TIMEOUT_EN
          else if (poll_cnt == POLL_MAX - 1) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            poll_cnt <= poll_cnt + 32'd1;
          end
`endif
        end
        S_READ: begin
          res_q <= rdata_i[7:0];
          state <= S_STORE;
        end
        S_STORE: begin
          if (last_win) begin
            x     <= ADDR_W'(1);
            y     <= ADDR_W'(1);
            state <= S_IDLE;
          end else begin
            state <= S_CTRL;
            if (x_wrap) begin
              x <= ADDR_W'(1);
              y <= y + ADDR_W'(1);
            end else begin
              x <= x + ADDR_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    sel_o      = 1'b0;
    we_o       = 1'b0;
    wdata_o    = '0;
    mem_addr_o = '0;
    res_we_o   = 1'b0;
    res_addr_o = '0;
    res_data_o = '0;
    case (state)
      S_CTRL: begin
        we_o       = 1'b1;
        wdata_o    = 32'h1;
        mem_addr_o = tap_addr(x, y, 4'd0);
      end
      S_SEND: begin
        sel_o      = 1'b1;
        we_o       = 1'b1;
        wdata_o    = {24'h0, mem_data_i};
        mem_addr_o = tap_addr(x, y, next_tap);
      end
      S_READ: sel_o = 1'b1;
      S_STORE: begin
        res_we_o   = 1'b1;
        res_addr_o = ADDR_W'((32'(y) - 32'd1) * (IMG_W - 2) + 32'(x) - 32'd1);
        res_data_o = res_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gauss_feeder.sv
// tb_gauss_feeder: scoreboard bench for gauss_feeder on a 3x3 and a 5x4 image, with a pixel RAM and filter model.
module tb_gauss_feeder;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  addr;
    logic [31:0] data;
  } ev_t;

  localparam logic [1:0] EV_CTRL  = 2'd0;
  localparam logic [1:0] EV_DATA  = 2'd1;
  localparam logic [1:0] EV_STORE = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start    [2];
  logic        busy     [2];
  logic        done     [2];
  logic        err      [2];
  logic        sel      [2];
  logic        we       [2];
  logic        res_we   [2];
  logic [7:0]  mem_addr [2];
  logic [7:0]  mem_data [2];
  logic [7:0]  res_addr [2];
  logic [7:0]  res_data [2];
  logic [31:0] wdata    [2];
  logic [31:0] rdata    [2];
  int unsigned polls    [2];

  logic [7:0]  pix [256];
  int unsigned poll_w;
  logic [7:0]  result;
  int          act;

  logic        a_busy, a_done, a_err, a_sel, a_we, a_res_we;
  logic [7:0]  a_res_addr, a_res_data;
  logic [31:0] a_wdata;

  ev_t        exp_q [$];
  logic [7:0] taps  [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gauss_feeder #(
      .IMG_W   ((g == 0) ? 3 : 5),
      .IMG_H   ((g == 0) ? 3 : 4),
      .ADDR_W  (8),
      .POLL_MAX(64)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start[g]),
      .busy_o    (busy[g]),
      .done_o    (done[g]),
      .err_o     (err[g]),
      .mem_addr_o(mem_addr[g]),
      .mem_data_i(mem_data[g]),
      .sel_o     (sel[g]),
      .we_o      (we[g]),
      .wdata_o   (wdata[g]),
      .rdata_i   (rdata[g]),
      .res_we_o  (res_we[g]),
      .res_addr_o(res_addr[g]),
      .res_data_o(res_data[g])
    );
  end

  // Pixel RAM with one-cycle read latency; filter reports done on poll number poll_w (0 = never).
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mem_data[i] <= pix[mem_addr[i]];
      if (we[i]) polls[i] <= 0;
      else if (busy[i] && !sel[i]) polls[i] <= polls[i] + 1;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rdata[i] = sel[i] ? {24'h0, result}
                        : {30'h0, (poll_w != 0) && (polls[i] + 1 >= poll_w), 1'b0};
    end
  end

  always_comb begin
    a_busy     = busy[act];
    a_done     = done[act];
    a_err      = err[act];
    a_sel      = sel[act];
    a_we       = we[act];
    a_res_we   = res_we[act];
    a_res_addr = res_addr[act];
    a_res_data = res_data[act];
    a_wdata    = wdata[act];
  end

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy[i], done[i], err[i], sel[i], we[i], res_we[i], mem_addr[i],
           res_addr[i], res_data[i], wdata[i]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst %0d: got busy %b we %b sel %b addr %h wdata %h, want all 0",
                 i, busy[i], we[i], sel[i], mem_addr[i], wdata[i]);
      end
    end
    rst = 1'b0; act = 0; poll_w = 1; result = 8'h11;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (a_sel !== 1'b1 || a_we !== 1'b1 || a_wdata !== {24'h0, pix[4]}) begin
      errors++;
      $display("FAIL reset_send_k4: got sel %b we %b wdata %h, want 1 1 %h", a_sel, a_we, a_wdata, {24'h0, pix[4]});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_sel, a_we, a_busy, a_res_we} !== 4'b0) begin
      errors++;
      $display("FAIL reset_abort: got sel %b we %b busy %b res_we %b, want 0 0 0 0", a_sel, a_we, a_busy, a_res_we);
    end
    rst = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (a_we || a_res_we || a_busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_quiet: got %0d active cycles after abort, want 0", bad);
    end
  endtask

  task automatic test_frame(input string nm, input int inst, input int unsigned pw,
                            input logic [7:0] res, input bit poke);
    int   w, h, wins, exp_done, cyc, done_cyc, stores, quiet;
    ev_t  e;
    logic [1:0] kind;
    w = (inst != 0) ? 5 : 3;
    h = (inst != 0) ? 4 : 3;
    wins = (w - 2) * (h - 2);
    exp_done = wins * (12 + int'(pw));
    act = inst; poll_w = pw; result = res;
    exp_q.delete(); taps.delete();
    for (int yy = 1; yy <= h - 2; yy++) begin
      for (int xx = 1; xx <= w - 2; xx++) begin
        exp_q.push_back('{EV_CTRL, 8'h0, 32'h1});
        for (int t = 0; t < 9; t++)
          exp_q.push_back('{EV_DATA, 8'h0, {24'h0, pix[(yy - 1 + t / 3) * w + xx - 1 + t % 3]}});
        exp_q.push_back('{EV_STORE, 8'((yy - 1) * (w - 2) + xx - 1), {24'h0, res}});
      end
    end
    cyc = 0; done_cyc = 0; stores = 0;
    @(negedge clk); start[inst] = 1'b1;
    @(negedge clk); start[inst] = 1'b0;
    while (done_cyc == 0 && cyc < exp_done + 40) begin
      cyc++;
      if (a_we) begin
        kind = a_sel ? EV_DATA : EV_CTRL;
        if (a_sel) taps.push_back(a_wdata[7:0]);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_write cyc %0d: got sel %b data %h, want none", nm, cyc, a_sel, a_wdata);
        end else begin
          e = exp_q.pop_front();
          if (kind !== e.kind || a_wdata !== e.data) begin
            errors++;
            $display("FAIL %s write cyc %0d: got kind %0d data %h, want kind %0d data %h",
                     nm, cyc, kind, a_wdata, e.kind, e.data);
          end
        end
      end
      if (a_res_we) begin
        stores++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_store cyc %0d: got addr %h data %h, want none", nm, cyc, a_res_addr, a_res_data);
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== EV_STORE || a_res_addr !== e.addr || a_res_data !== e.data[7:0]) begin
            errors++;
            $display("FAIL %s store cyc %0d: got addr %h data %h, want kind %0d addr %h data %h",
                     nm, cyc, a_res_addr, a_res_data, e.kind, e.addr, e.data[7:0]);
          end
        end
      end
      if (a_done) done_cyc = cyc;
      start[inst] = poke && (cyc == 20 || done_cyc != 0);
      if (done_cyc == 0) @(negedge clk);
    end
    checks++;
    if (done_cyc != exp_done) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d, want %0d", nm, done_cyc, exp_done);
    end
    checks++;
    if (stores != wins || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s store_count: got %0d stores, %0d events left, want %0d stores, 0 left",
               nm, stores, exp_q.size(), wins);
    end
    @(negedge clk); start[inst] = 1'b0;
    quiet = 0;
    repeat (4) begin
      if (a_busy || a_done || a_we || a_res_we) quiet++;
      @(negedge clk);
    end
    checks++;
    if (quiet != 0) begin
      errors++;
      $display("FAIL %s idle_after_done: got %0d active cycles, want 0", nm, quiet);
    end
  endtask

  task automatic test_taps();
    logic [7:0] want [9];
    want = '{8'h01, 8'h02, 8'h03, 8'h06, 8'h07, 8'h08, 8'h0B, 8'h0C, 8'h0D};
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (taps.size() < 18 || taps[9 + i] !== want[i]) begin
        errors++;
        $display("FAIL second_window_tap %0d: got %h (of %0d taps), want %h",
                 i, (taps.size() >= 18) ? taps[9 + i] : 8'hxx, taps.size(), want[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int stores, dones, cyc;
    logic b74, e74, b75, e75;
    act = 0; poll_w = 0; result = 8'h99;
    stores = 0; dones = 0; b74 = 0; e74 = 0; b75 = 0; e75 = 0;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
`ifdef GAUSS_FEEDER_TIMEOUT_EN
    for (cyc = 1; cyc <= 80; cyc++) begin
      if (a_res_we) stores++;
      if (a_done) dones++;
      if (cyc == 74) begin b74 = a_busy; e74 = a_err; end
      if (cyc == 75) begin b75 = a_busy; e75 = a_err; end
      @(negedge clk);
    end
    checks++;
    if ({b74, e74, b75, e75} !== 4'b1001) begin
      errors++;
      $display("FAIL timeout_edge: got busy/err %b%b at cyc74, %b%b at cyc75, want 10 then 01", b74, e74, b75, e75);
    end
    checks++;
    if (stores != 0 || dones != 0) begin
      errors++;
      $display("FAIL timeout_no_store: got %0d stores %0d dones, want 0 0", stores, dones);
    end
    poll_w = 1;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    checks++;
    if (a_err !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err_clear: got err %b busy %b, want 0 1", a_err, a_busy);
    end
    cyc = 0;
    while (a_busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (a_busy !== 1'b0 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: got busy %b err %b after %0d cycles, want 0 0", a_busy, a_err, cyc);
    end
`else
    for (cyc = 1; cyc <= 150; cyc++) begin
      if (a_res_we) stores++;
      if (a_done || a_err || !a_busy) dones++;
      @(negedge clk);
    end
    checks++;
    if (stores != 0 || dones != 0) begin
      errors++;
      $display("FAIL poll_forever: got %0d stores %0d idle/err cycles, want 0 0", stores, dones);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
  endtask

  initial begin
    logic [7:0] pa [9];
    rst = 1'b1; start[0] = 1'b0; start[1] = 1'b0;
    act = 0; poll_w = 1; result = 8'h0;
    for (int i = 0; i < 256; i++) pix[i] = 8'(i);
    test_reset();
    pa = '{8'hFF, 8'hA7, 8'hC2, 8'hF2, 8'hB7, 8'hB2, 8'hE1, 8'hA7, 8'hD9};
    for (int i = 0; i < 9; i++) pix[i] = pa[i];
    test_frame("win_poll3", 0, 3, 8'h5A, 1'b0);
    pa = '{8'h23, 8'h87, 8'h11, 8'h0A, 8'hF6, 8'h89, 8'hA0, 8'h65, 8'hB4};
    for (int i = 0; i < 9; i++) pix[i] = pa[i];
    test_frame("win_poll1", 0, 1, 8'h7C, 1'b0);
    for (int i = 0; i < 256; i++) pix[i] = 8'(i);
    test_frame("frame_5x4_busy_start", 1, 2, 8'h3C, 1'b1);
    test_taps();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
